// File: rtl/oam_dma_if.sv
// CPU-bus side of the sprite OAM DMA engine: CPU trigger inputs, DMA read data,
// and the hijacked bus drive. The engine masters the bus while it holds it.
interface oam_dma_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  dma_rdata;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_done;

  modport master (
    input  bus_addr, bus_din, bus_wr, odd_or_even, dma_rdata,
    output dma_hijack, dma_addr, dma_dout, dma_wr, dma_done
  );

  modport slave (
    output bus_addr, bus_din, bus_wr, odd_or_even, dma_rdata,
    input  dma_hijack, dma_addr, dma_dout, dma_wr, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write of page P to TRIG_ADDR halts the CPU and copies
// P00..P(N_BYTES-1) into OAMDATA as read/write pairs, with registered outputs.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004,
  parameter int unsigned N_BYTES   = 256
) (
  input logic       cpu_clk,
  input logic       reset_n,
  oam_dma_if.master bus
);

  localparam logic [7:0] LAST = 8'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] count;

  // dma_dout doubles as the read-data latch: it is loaded at the close of READ
  // and only changes there, so it holds its value in every other state.
  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      page           <= '0;
      count          <= '0;
      bus.dma_hijack <= 1'b0;
      bus.dma_addr   <= '0;
      bus.dma_dout   <= '0;
      bus.dma_wr     <= 1'b1;
      bus.dma_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.bus_addr == TRIG_ADDR && !bus.bus_wr) begin
            page           <= bus.bus_din;
            count          <= '0;
            state          <= HALT;
            bus.dma_hijack <= 1'b1;
            bus.dma_addr   <= '0;
            bus.dma_wr     <= 1'b1;
          end
        end
        HALT: begin
          if (bus.odd_or_even) begin
            state <= ALIGN;
          end else begin
            state        <= READ;
            bus.dma_addr <= {page, count};
          end
        end
        ALIGN: begin
          state        <= READ;
          bus.dma_addr <= {page, count};
        end
        READ: begin
          bus.dma_dout <= bus.dma_rdata;
          state        <= WRITE;
          bus.dma_addr <= OAM_ADDR;
          bus.dma_wr   <= 1'b0;
        end
        WRITE: begin
          bus.dma_wr <= 1'b1;
          if (count == LAST) begin
            state          <= DONE;
            bus.dma_hijack <= 1'b0;
            bus.dma_done   <= 1'b1;
            bus.dma_addr   <= '0;
          end else begin
            count        <= count + 8'd1;
            state        <= READ;
            bus.dma_addr <= {page, count + 8'd1};
          end
        end
        DONE: begin
          bus.dma_done <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues expected OAM writes and transfer
// lengths; a negedge monitor pops and compares them as the DUT presents them.
module tb_oam_dma;

  logic cpu_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  oam_dma_if bi ();
  oam_dma_if b2 ();

  assign bi.dma_rdata = ~bi.dma_addr[7:0];
  assign b2.dma_rdata = ~b2.dma_addr[7:0];

  oam_dma #(.TRIG_ADDR(16'h4014), .OAM_ADDR(16'h2004), .N_BYTES(256)) dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .bus(bi)
  );

  oam_dma #(.TRIG_ADDR(16'h4014), .OAM_ADDR(16'h2004), .N_BYTES(2)) dut2 (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .bus(b2)
  );

  typedef struct packed {
    logic [15:0] rd_addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wq[$];
  int unsigned lq[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Memory model returns ~addr[7:0], so byte i of any page reads back as ~i.
  task automatic exp_xfer(input logic [7:0] page, input int unsigned n, input int unsigned len);
    for (int unsigned i = 0; i < n; i++) begin
      wq.push_back('{rd_addr: {page, 8'(i)}, data: ~8'(i)});
    end
    if (len != 0) lq.push_back(len);
  endtask

  // Monitor: every write must be preceded by its read and match the queue head;
  // each done pulse closes a hijack run whose length must match.
  logic [15:0] prev_addr = '0;
  logic        prev_wr   = 1'b1;
  int unsigned hij_cnt   = 0;
  wr_t         e;
  int unsigned elen;

  always @(negedge cpu_clk) begin
    if (mon_en) begin
      if (bi.dma_hijack) begin
        hij_cnt++;
        if (!bi.dma_wr) begin
          if (wq.size() == 0) begin
            timeout("unexpected_write");
          end else begin
            e = wq.pop_front();
            chk("oam_write", 64'({bi.dma_addr, prev_addr, prev_wr, bi.dma_dout}),
                64'({16'h2004, e.rd_addr, 1'b1, e.data}));
          end
        end
        prev_addr = bi.dma_addr;
        prev_wr   = bi.dma_wr;
      end else begin
        if (bi.dma_done) begin
          if (lq.size() == 0) begin
            timeout("unexpected_done");
          end else begin
            elen = lq.pop_front();
            chk("hijack_len", 64'(hij_cnt), 64'(elen));
          end
        end
        hij_cnt = 0;
      end
    end
  end

  task automatic trig(input logic [7:0] p);
    bi.bus_addr = 16'h4014;
    bi.bus_wr   = 1'b0;
    bi.bus_din  = p;
    @(negedge cpu_clk);
    bi.bus_addr = 16'h0000;
    bi.bus_wr   = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (!bi.dma_done && n < 700) begin
      @(negedge cpu_clk);
      n++;
    end
    if (!bi.dma_done) timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int unsigned nw, g, h2, w2, d2;
    logic [7:0]  dlog[2];

    bi.bus_addr = '0; bi.bus_din = '0; bi.bus_wr = 1'b1; bi.odd_or_even = 1'b0;
    b2.bus_addr = '0; b2.bus_din = '0; b2.bus_wr = 1'b1; b2.odd_or_even = 1'b0;

    repeat (3) @(negedge cpu_clk);
    chk("reset_out", 64'({bi.dma_hijack, bi.dma_addr, bi.dma_dout, bi.dma_wr, bi.dma_done}),
        64'({1'b0, 16'h0000, 8'h00, 1'b1, 1'b0}));
    chk("reset_out_n2", 64'({b2.dma_hijack, b2.dma_addr, b2.dma_dout, b2.dma_wr, b2.dma_done}),
        64'({1'b0, 16'h0000, 8'h00, 1'b1, 1'b0}));
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge cpu_clk);

    // 1: even start, page $02
    exp_xfer(8'h02, 256, 513);
    trig(8'h02);
    chk("t1_hijack_rise", 64'({bi.dma_hijack, bi.dma_wr, bi.dma_addr}), 64'({1'b1, 1'b1, 16'h0000}));
    wait_done("t1_done");
    repeat (2) @(negedge cpu_clk);

    // 2: odd start adds the ALIGN cycle
    bi.odd_or_even = 1'b1;
    exp_xfer(8'h02, 256, 514);
    trig(8'h02);
    wait_done("t2_done");
    bi.odd_or_even = 1'b0;
    repeat (2) @(negedge cpu_clk);

    // 3: page $FF must not carry into the high byte
    exp_xfer(8'hFF, 256, 513);
    trig(8'hFF);
    wait_done("t3_done");
    repeat (2) @(negedge cpu_clk);

    // 4: reset during the 100th write aborts the transfer
    exp_xfer(8'h03, 100, 0);
    trig(8'h03);
    nw = 0;
    g  = 0;
    forever begin
      if (bi.dma_hijack && !bi.dma_wr) nw++;
      if (nw == 100 || g == 1000) break;
      @(negedge cpu_clk);
      g++;
    end
    if (nw != 100) timeout("t4_write100");
    reset_n = 1'b0;
    @(negedge cpu_clk);
    chk("t4_abort", 64'({bi.dma_hijack, bi.dma_wr, bi.dma_done}), 64'(3'b010));
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge cpu_clk);
      chk("t4_quiet", 64'({bi.dma_hijack, bi.dma_wr}), 64'(2'b01));
    end
    exp_xfer(8'h03, 256, 513);
    trig(8'h03);
    wait_done("t4_restart_done");
    repeat (2) @(negedge cpu_clk);

    // 5: trigger during READ and a CPU read of $4014 are both ignored
    exp_xfer(8'h04, 256, 513);
    trig(8'h04);
    g = 0;
    while (!(bi.dma_hijack && bi.dma_wr && bi.dma_addr[15:8] == 8'h04) && g < 20) begin
      @(negedge cpu_clk);
      g++;
    end
    if (g == 20) timeout("t5_read");
    bi.bus_addr = 16'h4014; bi.bus_wr = 1'b0; bi.bus_din = 8'h55;
    @(negedge cpu_clk);
    bi.bus_addr = 16'h0000; bi.bus_wr = 1'b1;
    wait_done("t5_done");
    @(negedge cpu_clk);
    bi.bus_addr = 16'h4014; bi.bus_wr = 1'b1; bi.bus_din = 8'h09;
    repeat (5) begin
      @(negedge cpu_clk);
      chk("t5_idle_read", 64'(bi.dma_hijack), 64'(1'b0));
    end
    bi.bus_addr = 16'h0000;
    repeat (2) @(negedge cpu_clk);

    // 6: trigger in DONE is dropped, trigger in the following IDLE starts
    exp_xfer(8'h05, 256, 513);
    trig(8'h05);
    wait_done("t6_first_done");
    bi.bus_addr = 16'h4014; bi.bus_wr = 1'b0; bi.bus_din = 8'h07;
    @(negedge cpu_clk);
    bi.bus_din = 8'h06;
    exp_xfer(8'h06, 256, 513);
    @(negedge cpu_clk);
    bi.bus_addr = 16'h0000; bi.bus_wr = 1'b1;
    chk("t6_halt_next", 64'(bi.dma_hijack), 64'(1'b1));
    wait_done("t6_second_done");
    repeat (2) @(negedge cpu_clk);

    // N_BYTES=2 instance: exactly two read/write pairs
    b2.bus_addr = 16'h4014; b2.bus_wr = 1'b0; b2.bus_din = 8'h10;
    @(negedge cpu_clk);
    b2.bus_addr = 16'h0000; b2.bus_wr = 1'b1;
    h2 = 0; w2 = 0; d2 = 0;
    dlog[0] = '0; dlog[1] = '0;
    repeat (10) begin
      if (b2.dma_hijack) h2++;
      if (b2.dma_hijack && !b2.dma_wr) begin
        if (w2 < 2) dlog[w2] = b2.dma_dout;
        w2++;
      end
      if (b2.dma_done) d2++;
      @(negedge cpu_clk);
    end
    chk("n2_hijack_len", 64'(h2), 64'(5));
    chk("n2_writes", 64'(w2), 64'(2));
    chk("n2_data", 64'({dlog[0], dlog[1]}), 64'(16'hFFFE));
    chk("n2_done", 64'(d2), 64'(1));

    repeat (5) @(negedge cpu_clk);
    chk("queues_empty", 64'({wq.size(), lq.size()}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
